// File: rtl/xera4_pkg.sv
// ---------------------------------------------------------------------------
// xera4_pkg
// Shared definitions for the xera4 port peripherals: register offsets within
// the 7-byte port window, CTRL bit positions, and the timer / MI state
// encodings.
// ---------------------------------------------------------------------------
package xera4_pkg;

    // Register offsets relative to BASE
    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_RELOAD_L = 3'd1;
    localparam logic [2:0] OFF_RELOAD_H = 3'd2;
    localparam logic [2:0] OFF_PRESCALE = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;
    localparam logic [2:0] OFF_COUNT_L  = 3'd5;
    localparam logic [2:0] OFF_COUNT_H  = 3'd6;
    localparam logic [2:0] OFF_LAST     = OFF_COUNT_H;

    // CTRL bit indices
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IRQ  = 2;

    // MI stays high for two clocks after each low pulse (count loaded as N-1)
    localparam logic [3:0] MI_GAP_CNT = 4'd1;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } tmr_state_e;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_LOW  = 2'd1,
        M_GAP  = 2'd2
    } mi_state_e;

endpackage

// File: rtl/xera4_port_wdet.sv
// ---------------------------------------------------------------------------
// xera4_port_wdet
// Port write-event detector and window decode, shared by xera4 port
// peripherals. The CPU holds its write strobe level between OUT
// instructions, so a write is recognised as a strobe that is high and either
// newly risen or accompanied by a changed address or data value, relative to
// the values seen on the previous clock. History resets to zero, so a strobe
// already high when reset is released still produces one event.
//
// Ports
//   clk, rst_n      clock, async active-low reset
//   port_add_i      CPU port address
//   port_out_i      CPU write data
//   port_we_i       CPU write level
//   wr_evt_o        write event this clock (any address)
//   in_win_o        port_add_i lies within BASE..BASE+OFF_LAST
//   offset_o        port_add_i - BASE (valid when in_win_o)
//   add_chg_o       port_add_i differs from the previous clock
// ---------------------------------------------------------------------------
module xera4_port_wdet
    import xera4_pkg::*;
#(
    parameter logic [15:0] BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] port_add_i,
    input  logic [7:0]  port_out_i,
    input  logic        port_we_i,
    output logic        wr_evt_o,
    output logic        in_win_o,
    output logic [2:0]  offset_o,
    output logic        add_chg_o
);

    logic [15:0] add_q;
    logic [7:0]  out_q;
    logic        we_q;
    logic [15:0] rel;

    // Unsigned subtraction: addresses below BASE wrap to large values and
    // fall outside the window with a single compare.
    assign rel       = port_add_i - BASE;
    assign in_win_o  = (rel <= {13'd0, OFF_LAST});
    assign offset_o  = rel[2:0];
    assign add_chg_o = (port_add_i != add_q);
    assign wr_evt_o  = port_we_i & (~we_q | add_chg_o | (port_out_i != out_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_q <= 16'h0000;
            out_q <= 8'h00;
            we_q  <= 1'b0;
        end else begin
            add_q <= port_add_i;
            out_q <= port_out_i;
            we_q  <= port_we_i;
        end
    end

endmodule

// File: rtl/xera4_port_timer.sv
// ---------------------------------------------------------------------------
// xera4_port_timer
// CPU-port mapped 16-bit down-counting timer with prescaler, auto-reload and
// a pulsed active-low interrupt line.
//
// Ports
//   clk, rst_n   clock, async active-low reset
//   Port_Add     CPU port address
//   Port_Out     CPU write data
//   Port_we      CPU write level (held between OUT instructions)
//   Port_In      registered read data, 8'h00 outside the window
//   MI           interrupt, idle high, low pulse of PULSE_LEN clocks
//
// Timer FSM
//   state  | meaning
//   T_IDLE | counter halted, holds its value
//   T_RUN  | prescaler running, counter decrements on each tick
//
// MI FSM
//   state  | meaning
//   M_IDLE | MI high, waiting for an interrupting expiry
//   M_LOW  | MI low for PULSE_LEN clocks
//   M_GAP  | MI high for two clocks; further expiries are dropped
// ---------------------------------------------------------------------------
module xera4_port_timer
    import xera4_pkg::*;
#(
    parameter logic [15:0] BASE      = 16'hFF00,
    parameter int unsigned PULSE_LEN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Port_Add,
    input  logic [7:0]  Port_Out,
    input  logic        Port_we,
    output logic [7:0]  Port_In,
    output logic        MI
);

    localparam logic [3:0] PULSE_CNT = 4'(PULSE_LEN - 1);

    logic       wr_evt;
    logic       in_win;
    logic       add_chg;
    logic [2:0] offset;
    logic       wr;

    logic [2:0]  ctrl_q,     ctrl_d;
    logic [7:0]  reload_l_q, reload_l_d;
    logic [7:0]  reload_h_q, reload_h_d;
    logic [7:0]  prescale_q, prescale_d;
    logic        expired_q,  expired_d;
    logic [15:0] count_q,    count_d;
    logic [7:0]  psc_q,      psc_d;
    logic [7:0]  shadow_q,   shadow_d;
    logic [7:0]  port_in_q,  port_in_d;
    logic        irq_pend_q, irq_pend_d;
    logic        mi_q,       mi_d;
    logic [3:0]  mi_cnt_q,   mi_cnt_d;
    tmr_state_e  tmr_state_q, tmr_state_d;
    mi_state_e   mi_state_q,  mi_state_d;

    logic        en_rise;
    logic        en_fall;
    logic        expiry;

    xera4_port_wdet #(
        .BASE (BASE)
    ) u_wdet (
        .clk        (clk),
        .rst_n      (rst_n),
        .port_add_i (Port_Add),
        .port_out_i (Port_Out),
        .port_we_i  (Port_we),
        .wr_evt_o   (wr_evt),
        .in_win_o   (in_win),
        .offset_o   (offset),
        .add_chg_o  (add_chg)
    );

    assign wr      = wr_evt & in_win;
    assign en_rise = wr & (offset == OFF_CTRL) & ~ctrl_q[CTRL_EN] &  Port_Out[CTRL_EN];
    assign en_fall = wr & (offset == OFF_CTRL) &  ctrl_q[CTRL_EN] & ~Port_Out[CTRL_EN];

    // Register file writes, timer FSM and expiry
    always_comb begin
        ctrl_d      = ctrl_q;
        reload_l_d  = reload_l_q;
        reload_h_d  = reload_h_q;
        prescale_d  = prescale_q;
        expired_d   = expired_q;
        count_d     = count_q;
        psc_d       = psc_q;
        tmr_state_d = tmr_state_q;
        expiry      = 1'b0;

        if (wr) begin
            case (offset)
                OFF_CTRL:     ctrl_d     = Port_Out[2:0];
                OFF_RELOAD_L: reload_l_d = Port_Out;
                OFF_RELOAD_H: reload_h_d = Port_Out;
                OFF_PRESCALE: prescale_d = Port_Out;
                OFF_STATUS:   if (Port_Out[0]) expired_d = 1'b0;
                default:      ;
            endcase
        end

        // Loads always use the reload value held before this clock's writes.
        case (tmr_state_q)
            T_IDLE: begin
                if (en_rise) begin
                    tmr_state_d = T_RUN;
                    count_d     = {reload_h_q, reload_l_q};
                    psc_d       = 8'h00;
                end
            end
            T_RUN: begin
                if (en_fall) begin
                    tmr_state_d = T_IDLE;
                end else if (psc_q == prescale_q) begin
                    psc_d = 8'h00;
                    if (count_q == 16'h0000) begin
                        expiry = 1'b1;
                        if (ctrl_q[CTRL_AUTO]) begin
                            count_d = {reload_h_q, reload_l_q};
                        end else begin
                            ctrl_d[CTRL_EN] = 1'b0;
                            tmr_state_d     = T_IDLE;
                        end
                    end else begin
                        count_d = count_q - 16'd1;
                    end
                end else begin
                    psc_d = psc_q + 8'd1;
                end
            end
            default: tmr_state_d = T_IDLE;
        endcase

        // Expiry beats a simultaneous clear
        if (expiry) expired_d = 1'b1;
    end

    assign irq_pend_d = expiry & ctrl_q[CTRL_IRQ];

    // COUNT_H shadow captures the high byte when the CPU moves onto COUNT_L,
    // giving a coherent 16-bit snapshot across the two byte reads.
    always_comb begin
        shadow_d = shadow_q;
        if (add_chg && in_win && (offset == OFF_COUNT_L)) shadow_d = count_q[15:8];
    end

    always_comb begin
        port_in_d = 8'h00;
        if (in_win) begin
            case (offset)
                OFF_CTRL:     port_in_d = {5'd0, ctrl_q};
                OFF_RELOAD_L: port_in_d = reload_l_q;
                OFF_RELOAD_H: port_in_d = reload_h_q;
                OFF_PRESCALE: port_in_d = prescale_q;
                OFF_STATUS:   port_in_d = {7'd0, expired_q};
                OFF_COUNT_L:  port_in_d = count_q[7:0];
                OFF_COUNT_H:  port_in_d = shadow_q;
                default:      port_in_d = 8'h00;
            endcase
        end
    end

    // MI FSM. The expiry is registered first, so MI falls on the clock after
    // the expiry. An expiry arriving exactly as the gap completes starts the
    // next pulse, which lets a 4-clock expiry period give a steady
    // low-2/high-2 waveform.
    always_comb begin
        mi_state_d = mi_state_q;
        mi_cnt_d   = mi_cnt_q;
        case (mi_state_q)
            M_IDLE: begin
                if (irq_pend_q) begin
                    mi_state_d = M_LOW;
                    mi_cnt_d   = PULSE_CNT;
                end
            end
            M_LOW: begin
                if (mi_cnt_q == 4'd0) begin
                    mi_state_d = M_GAP;
                    mi_cnt_d   = MI_GAP_CNT;
                end else begin
                    mi_cnt_d = mi_cnt_q - 4'd1;
                end
            end
            M_GAP: begin
                if (mi_cnt_q == 4'd0) begin
                    if (irq_pend_q) begin
                        mi_state_d = M_LOW;
                        mi_cnt_d   = PULSE_CNT;
                    end else begin
                        mi_state_d = M_IDLE;
                    end
                end else begin
                    mi_cnt_d = mi_cnt_q - 4'd1;
                end
            end
            default: mi_state_d = M_IDLE;
        endcase
        mi_d = (mi_state_d != M_LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= 3'd0;
            reload_l_q  <= 8'h00;
            reload_h_q  <= 8'h00;
            prescale_q  <= 8'h00;
            expired_q   <= 1'b0;
            count_q     <= 16'h0000;
            psc_q       <= 8'h00;
            shadow_q    <= 8'h00;
            port_in_q   <= 8'h00;
            irq_pend_q  <= 1'b0;
            mi_q        <= 1'b1;
            mi_cnt_q    <= 4'd0;
            tmr_state_q <= T_IDLE;
            mi_state_q  <= M_IDLE;
        end else begin
            ctrl_q      <= ctrl_d;
            reload_l_q  <= reload_l_d;
            reload_h_q  <= reload_h_d;
            prescale_q  <= prescale_d;
            expired_q   <= expired_d;
            count_q     <= count_d;
            psc_q       <= psc_d;
            shadow_q    <= shadow_d;
            port_in_q   <= port_in_d;
            irq_pend_q  <= irq_pend_d;
            mi_q        <= mi_d;
            mi_cnt_q    <= mi_cnt_d;
            tmr_state_q <= tmr_state_d;
            mi_state_q  <= mi_state_d;
        end
    end

    assign Port_In = port_in_q;
    assign MI      = mi_q;

endmodule
